// File: rtl/reg_bank_param_if.sv
// rtl/reg_bank_param_if.sv - read/write/issue bus of the parametrised register bank
// Purpose: groups the decode-side read and issue signals and the writeback-side
//          write signals of reg_bank_param into one bundle.
// Signals: rd_en, rd_addr1/2 -> rd_data1/2 (registered), rd_busy1/2 (comb)
//          wr_en, wr_addr, wr_data (writeback), iss_en, iss_addr (dest reserve)
//          busy_cnt (registered popcount of busy bits)
interface reg_bank_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, busy_cnt
    );

    modport slave (
        input  rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, busy_cnt
    );
endinterface

// File: rtl/reg_bank_param.sv
// rtl/reg_bank_param.sv - DEPTH x DATA_W register file with bypass and busy scoreboard
// Purpose: two registered read ports, one synchronous write port with optional
//          write-to-read forwarding, and a per-register busy scoreboard used by
//          the control FSM to detect RAW hazards.
// Ports:   clk   - rising-edge clock
//          reset - asynchronous active-high reset
//          bus   - reg_bank_param_if slave modport (read, write, issue, status)
module reg_bank_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int INIT_STEP = 4,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic            clk,
    input  logic            reset,
    reg_bank_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DATA_W-1:0] r_rd_data1;
    logic [DATA_W-1:0] r_rd_data2;
    logic [ADDR_W:0]   r_busy_cnt;

    logic              w_wr_ok;
    logic [DEPTH-1:0]  w_busy_next;
    logic [ADDR_W:0]   w_busy_cnt;
    logic [DATA_W-1:0] w_rd_next1;
    logic [DATA_W-1:0] w_rd_next2;

    // A write to the hardwired zero register is dropped entirely, including
    // for forwarding purposes.
    assign w_wr_ok = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

    // Read-port next values: storage, then forwarded write data, then the
    // zero-register override, which has the final say.
    always_comb begin
        w_rd_next1 = r_mem[bus.rd_addr1];
        w_rd_next2 = r_mem[bus.rd_addr2];
        if ((BYPASS != 0) && w_wr_ok && (bus.wr_addr == bus.rd_addr1)) begin
            w_rd_next1 = bus.wr_data;
        end
        if ((BYPASS != 0) && w_wr_ok && (bus.wr_addr == bus.rd_addr2)) begin
            w_rd_next2 = bus.wr_data;
        end
        if ((ZERO_REG != 0) && (bus.rd_addr1 == '0)) begin
            w_rd_next1 = '0;
        end
        if ((ZERO_REG != 0) && (bus.rd_addr2 == '0)) begin
            w_rd_next2 = '0;
        end
    end

    // Clear by writeback first, then set by issue, so a same-cycle issue to
    // the register being written leaves it busy for the new producer.
    always_comb begin
        w_busy_next = r_busy;
        if (bus.wr_en) begin
            w_busy_next[bus.wr_addr] = 1'b0;
        end
        if (bus.iss_en) begin
            w_busy_next[bus.iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_busy_next[0] = 1'b0;
        end
    end

    // Count from the next-state vector so busy_cnt matches r_busy after the edge.
    always_comb begin
        w_busy_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_busy_cnt = w_busy_cnt + {{ADDR_W{1'b0}}, w_busy_next[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_W'(i * INIT_STEP);
            end
            r_busy     <= '0;
            r_rd_data1 <= '0;
            r_rd_data2 <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wr_ok) begin
                r_mem[bus.wr_addr] <= bus.wr_data;
            end
            if (bus.rd_en) begin
                r_rd_data1 <= w_rd_next1;
                r_rd_data2 <= w_rd_next2;
            end
            r_busy     <= w_busy_next;
            r_busy_cnt <= w_busy_cnt;
        end
    end

    assign bus.rd_data1 = r_rd_data1;
    assign bus.rd_data2 = r_rd_data2;
    // Busy lookup uses the current state only; this cycle's issue/write is not seen.
    assign bus.rd_busy1 = r_busy[bus.rd_addr1];
    assign bus.rd_busy2 = r_busy[bus.rd_addr2];
    assign bus.busy_cnt = r_busy_cnt;
endmodule

// File: tb/tb_reg_bank_param.sv
// tb/tb_reg_bank_param.sv - scoreboard bench for reg_bank_param (bypass and no-bypass)
module tb_reg_bank_param;
    logic clk;
    logic reset;

    reg_bank_param_if #(.DATA_W(32), .ADDR_W(4)) bus ();
    reg_bank_param_if #(.DATA_W(32), .ADDR_W(4)) bus_nb ();

    reg_bank_param #(.DATA_W(32), .ADDR_W(4), .INIT_STEP(4), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    reg_bank_param #(.DATA_W(32), .ADDR_W(4), .INIT_STEP(4), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nb)
    );

    assign bus_nb.rd_en    = bus.rd_en;
    assign bus_nb.rd_addr1 = bus.rd_addr1;
    assign bus_nb.rd_addr2 = bus.rd_addr2;
    assign bus_nb.wr_en    = bus.wr_en;
    assign bus_nb.wr_addr  = bus.wr_addr;
    assign bus_nb.wr_data  = bus.wr_data;
    assign bus_nb.iss_en   = bus.iss_en;
    assign bus_nb.iss_addr = bus.iss_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [4:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rd(input string nm, input logic [3:0] a1, input logic [3:0] a2,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic [31:0] n1, input logic [31:0] n2, input logic [4:0] c);
        exp_t e;
        bus.rd_en    = 1'b1;
        bus.rd_addr1 = a1;
        bus.rd_addr2 = a2;
        e.nm = nm; e.e1 = e1; e.e2 = e2; e.n1 = n1; e.n2 = n2; e.cnt = c;
        sb.push_back(e);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    task automatic iss(input logic [3:0] a);
        bus.iss_en   = 1'b1;
        bus.iss_addr = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.rd_en  = 1'b0;
        bus.wr_en  = 1'b0;
        bus.iss_en = 1'b0;
    endtask

    // Monitor: every accepted read presents data one edge later; pop and compare.
    initial begin
        forever begin
            @(posedge clk);
            if (bus.rd_en && !reset) begin
                #1;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got read with no expectation, expected queued entry");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.nm, ".d1"},     bus.rd_data1,           e.e1);
                    chk({e.nm, ".d2"},     bus.rd_data2,           e.e2);
                    chk({e.nm, ".nb_d1"},  bus_nb.rd_data1,        e.n1);
                    chk({e.nm, ".nb_d2"},  bus_nb.rd_data2,        e.n2);
                    chk({e.nm, ".cnt"},    32'(bus.busy_cnt),      32'(e.cnt));
                    chk({e.nm, ".nb_cnt"}, 32'(bus_nb.busy_cnt),   32'(e.cnt));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.rd_en    = 1'b0;
        bus.rd_addr1 = '0;
        bus.rd_addr2 = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst.d1",  bus.rd_data1,      32'h0);
        chk("rst.d2",  bus.rd_data2,      32'h0);
        chk("rst.cnt", 32'(bus.busy_cnt), 32'h0);

        // Reset contents
        rd("t1", 4'd3, 4'd15, 32'd12, 32'd60, 32'd12, 32'd60, 5'd0); tick();

        // Write-to-read bypass vs. no bypass
        wr(4'd5, 32'hDEADBEEF);
        rd("t2_same", 4'd5, 4'd4, 32'hDEADBEEF, 32'd16, 32'd20, 32'd16, 5'd0); tick();
        rd("t2_next", 4'd5, 4'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 5'd0); tick();

        // Zero register
        wr(4'd0, 32'h1234);
        rd("t3_same", 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0); tick();
        rd("t3_next", 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0); tick();
        iss(4'd0);
        rd("t3_iss0", 4'd0, 4'd3, 32'd0, 32'd12, 32'd0, 32'd12, 5'd0); tick();

        // Scoreboard set/clear/priority
        iss(4'd7);
        rd("t4_iss", 4'd1, 4'd2, 32'd4, 32'd8, 32'd4, 32'd8, 5'd1); tick();
        bus.rd_addr1 = 4'd7; bus.rd_addr2 = 4'd6; #1;
        chk("t4.busy1_set", 32'(bus.rd_busy1), 32'd1);
        chk("t4.busy2_idle", 32'(bus.rd_busy2), 32'd0);
        wr(4'd7, 32'h77);
        rd("t4_wr", 4'd7, 4'd6, 32'h77, 32'd24, 32'd28, 32'd24, 5'd0); tick();
        bus.rd_addr1 = 4'd7; #1;
        chk("t4.busy1_clr", 32'(bus.rd_busy1), 32'd0);
        iss(4'd7);
        rd("t4_reiss", 4'd7, 4'd7, 32'h77, 32'h77, 32'h77, 32'h77, 5'd1); tick();
        bus.rd_addr1 = 4'd7; #1;
        chk("t4.busy1_pre", 32'(bus.rd_busy1), 32'd1);
        iss(4'd7); wr(4'd7, 32'h99);
        rd("t4_both", 4'd7, 4'd1, 32'h99, 32'd4, 32'h77, 32'd4, 5'd1); tick();
        bus.rd_addr1 = 4'd7; #1;
        chk("t4.busy1_win", 32'(bus.rd_busy1), 32'd1);
        iss(4'd7);
        rd("t4_issbusy", 4'd7, 4'd7, 32'h99, 32'h99, 32'h99, 32'h99, 5'd1); tick();
        wr(4'd7, 32'hAA);
        rd("t4_clr", 4'd2, 4'd3, 32'd8, 32'd12, 32'd8, 32'd12, 5'd0); tick();

        // Async reset in the middle of a write
        iss(4'd2);
        rd("t5_i2", 4'd2, 4'd3, 32'd8, 32'd12, 32'd8, 32'd12, 5'd1); tick();
        iss(4'd3);
        rd("t5_i3", 4'd4, 4'd5, 32'd16, 32'hDEADBEEF, 32'd16, 32'hDEADBEEF, 5'd2); tick();
        iss(4'd4); wr(4'd4, 32'h4444);
        #2;
        reset = 1'b1;
        #1;
        chk("t5.rst_d1",     bus.rd_data1,         32'h0);
        chk("t5.rst_d2",     bus.rd_data2,         32'h0);
        chk("t5.rst_cnt",    32'(bus.busy_cnt),    32'h0);
        chk("t5.rst_nb_d2",  bus_nb.rd_data2,      32'h0);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0; bus.iss_en = 1'b0;
        reset = 1'b0;
        rd("t5_r4", 4'd4, 4'd5, 32'd16, 32'd20, 32'd16, 32'd20, 5'd0); tick();
        rd("t5_r7", 4'd7, 4'd2, 32'd28, 32'd8, 32'd28, 32'd8, 5'd0); tick();
        bus.rd_addr1 = 4'd2; #1;
        chk("t5.busy_lost", 32'(bus.rd_busy1), 32'd0);

        // Fill and drain the scoreboard
        for (int i = 1; i < 16; i++) begin
            iss(4'(i));
            rd("t6_iss", 4'(i), 4'd0, 32'(4 * i), 32'd0, 32'(4 * i), 32'd0, 5'(i)); tick();
        end
        bus.rd_addr1 = 4'd15; bus.rd_addr2 = 4'd0; #1;
        chk("t6.busy15", 32'(bus.rd_busy1), 32'd1);
        chk("t6.busy0",  32'(bus.rd_busy2), 32'd0);
        iss(4'd0);
        rd("t6_iss0", 4'd0, 4'd15, 32'd0, 32'd60, 32'd0, 32'd60, 5'd15); tick();
        for (int i = 1; i < 16; i++) begin
            wr(4'(i), 32'(i * 32'h1010));
            rd("t6_wr", 4'(i), 4'd0, 32'(i * 32'h1010), 32'd0, 32'(4 * i), 32'd0, 5'(15 - i)); tick();
        end
        rd("t6_end", 4'd1, 4'd15, 32'h1010, 32'hF0F0, 32'h1010, 32'hF0F0, 5'd0); tick();

        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
